// File: rtl/vim_pkg.sv
// Shared types for the vector classifier.
// Class codes are used by both the classifier and the counters.
package vim_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO    = 3'd0,
    CLS_ONEHOT  = 3'd1,
    CLS_ALLONES = 3'd2,
    CLS_MULTI   = 3'd3,
    CLS_UNKNOWN = 3'd4
  } vec_class_e;

  localparam int unsigned NUM_KNOWN = 4;

endpackage

// File: rtl/vim_classify.sv
// Combinational classifier: popcount plus class decode.
// VIM_XCHK_EN adds X/Z detection mapping to CLS_UNKNOWN.
module vim_classify
  import vim_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ONES_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]  in_data,
  output vec_class_e        cls,
  output logic [ONES_W-1:0] ones
);

  logic [ONES_W-1:0] cnt;

  // Population count of the input vector
  always_comb begin
    cnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt = cnt + ONES_W'(in_data[i]);
    end
  end

  // Decode count to class; all-ones outranks multi
  always_comb begin
    ones = cnt;
    unique case (1'b1)
      (cnt == '0):                 cls = CLS_ZERO;
      (cnt == ONES_W'(1)):         cls = CLS_ONEHOT;
      (cnt == ONES_W'(WIDTH)):     cls = CLS_ALLONES;
      default:                     cls = CLS_MULTI;
    endcase
`ifdef VIM_XCHK_EN
    if ($isunknown(in_data)) begin
      cls  = CLS_UNKNOWN;
      ones = '0;
    end
`endif
  end

endmodule

// File: rtl/vim.sv
// Vector classifier with 1-deep output register and per-class counters.
// Define VIM_XCHK_EN to enable X/Z detection and cnt_unknown.
module vim
  import vim_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [WIDTH-1:0]             ref_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2:0]                   out_class,
  output logic [$clog2(WIDTH+1)-1:0]   out_ones,
  output logic                         out_eq,
  input  logic                         clr_stats,
  output logic [CNT_W-1:0]             cnt_zero,
  output logic [CNT_W-1:0]             cnt_onehot,
  output logic [CNT_W-1:0]             cnt_allones,
  output logic [CNT_W-1:0]             cnt_multi,
  output logic [CNT_W-1:0]             cnt_unknown
);

  localparam int unsigned ONES_W = $clog2(WIDTH + 1);

  vec_class_e        cls;
  logic [ONES_W-1:0] ones;
  logic              eq;
  logic              xfer;

  logic              out_valid_d, out_valid_q;
  vec_class_e        out_class_d, out_class_q;
  logic [ONES_W-1:0] out_ones_d,  out_ones_q;
  logic              out_eq_d,    out_eq_q;

  logic [CNT_W-1:0]  cnt_d [NUM_KNOWN];
  logic [CNT_W-1:0]  cnt_q [NUM_KNOWN];

  vim_classify #(
    .WIDTH  (WIDTH),
    .ONES_W (ONES_W)
  ) u_classify (
    .in_data (in_data),
    .cls     (cls),
    .ones    (ones)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  // Equality only counts when both operands are fully known
  always_comb begin
    eq = (in_data == ref_data);
`ifdef VIM_XCHK_EN
    if ($isunknown(in_data) || $isunknown(ref_data)) begin
      eq = 1'b0;
    end
`endif
  end

  // Output register: load on transfer, drop valid once consumed
  always_comb begin
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_ones_d  = out_ones_q;
    out_eq_d    = out_eq_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_class_d = cls;
      out_ones_d  = ones;
      out_eq_d    = eq;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_class_q <= CLS_ZERO;
      out_ones_q  <= '0;
      out_eq_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_ones_q  <= out_ones_d;
      out_eq_q    <= out_eq_d;
    end
  end

  // Saturating per-class counters; clear beats a same-cycle transfer
  always_comb begin
    for (int k = 0; k < int'(NUM_KNOWN); k++) begin
      cnt_d[k] = cnt_q[k];
    end
    if (clr_stats) begin
      for (int k = 0; k < int'(NUM_KNOWN); k++) begin
        cnt_d[k] = '0;
      end
    end else if (xfer && cls != CLS_UNKNOWN) begin
      if (cnt_q[cls[1:0]] != '1) begin
        cnt_d[cls[1:0]] = cnt_q[cls[1:0]] + CNT_W'(1);
      end
    end
  end

  // Counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_KNOWN); k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NUM_KNOWN); k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

`ifdef VIM_XCHK_EN
  logic [CNT_W-1:0] unk_d, unk_q;

  // Unknown-class counter, same clear/saturate rules
  always_comb begin
    unk_d = unk_q;
    if (clr_stats) begin
      unk_d = '0;
    end else if (xfer && cls == CLS_UNKNOWN && unk_q != '1) begin
      unk_d = unk_q + CNT_W'(1);
    end
  end

  // Unknown counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unk_q <= '0;
    end else begin
      unk_q <= unk_d;
    end
  end

  assign cnt_unknown = unk_q;
`else
  assign cnt_unknown = '0;
`endif

  assign out_valid   = out_valid_q;
  assign out_class   = out_class_q;
  assign out_ones    = out_ones_q;
  assign out_eq      = out_eq_q;
  assign cnt_zero    = cnt_q[CLS_ZERO[1:0]];
  assign cnt_onehot  = cnt_q[CLS_ONEHOT[1:0]];
  assign cnt_allones = cnt_q[CLS_ALLONES[1:0]];
  assign cnt_multi   = cnt_q[CLS_MULTI[1:0]];

endmodule

// File: tb/tb_vim.sv
// Scoreboard bench for vim (WIDTH=4, CNT_W=2).
// Define VIM_XCHK_EN to also exercise X/Z classification.
module tb_vim;
  import vim_pkg::*;

  localparam int W  = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic [2:0] cls;
    logic [2:0] ones;
    logic       eq;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [W-1:0]  ref_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_class;
  logic [2:0]    out_ones;
  logic          out_eq;
  logic          clr_stats;
  logic [CW-1:0] cnt_zero, cnt_onehot, cnt_allones;
  logic [CW-1:0] cnt_multi, cnt_unknown;

  int            n_chk  = 0;
  int            n_fail = 0;
  exp_t          sb[$];
  exp_t          mon_e;
  logic [CW-1:0] m_cnt [5];

  always #5 clk = ~clk;

  vim #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .ref_data    (ref_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_class   (out_class),
    .out_ones    (out_ones),
    .out_eq      (out_eq),
    .clr_stats   (clr_stats),
    .cnt_zero    (cnt_zero),
    .cnt_onehot  (cnt_onehot),
    .cnt_allones (cnt_allones),
    .cnt_multi   (cnt_multi),
    .cnt_unknown (cnt_unknown)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] d,
                                 input logic [W-1:0] r);
    exp_t e;
    int   n = 0;
    for (int i = 0; i < W; i++) if (d[i] === 1'b1) n++;
    e.ones = 3'(n);
    e.eq   = (d === r);
    if (n == 0)      e.cls = 3'd0;
    else if (n == W) e.cls = 3'd2;
    else if (n == 1) e.cls = 3'd1;
    else             e.cls = 3'd3;
`ifdef VIM_XCHK_EN
    if ((^d === 1'bx) || (^r === 1'bx)) e.eq = 1'b0;
    if (^d === 1'bx) begin
      e.cls  = 3'd4;
      e.ones = 3'd0;
    end
`endif
    return e;
  endfunction

  // Scoreboard: pop on output handshake, push on input handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      for (int k = 0; k < 5; k++) m_cnt[k] = '0;
    end else begin
      check("cnt_zero",    cnt_zero,    m_cnt[0]);
      check("cnt_onehot",  cnt_onehot,  m_cnt[1]);
      check("cnt_allones", cnt_allones, m_cnt[2]);
      check("cnt_multi",   cnt_multi,   m_cnt[3]);
      check("cnt_unknown", cnt_unknown, m_cnt[4]);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("sb_class", out_class, mon_e.cls);
          check("sb_ones",  out_ones,  mon_e.ones);
          check("sb_eq",    out_eq,    mon_e.eq);
        end
      end
      if (clr_stats) begin
        for (int k = 0; k < 5; k++) m_cnt[k] = '0;
      end else if (in_valid && in_ready) begin
        mon_e = model(in_data, ref_data);
        if (m_cnt[mon_e.cls] != '1) m_cnt[mon_e.cls]++;
      end
      if (in_valid && in_ready) sb.push_back(model(in_data, ref_data));
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] r);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    ref_data = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] c,
                            input logic [2:0] n, input logic e);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_class"}, out_class, c);
    check({tag, "_ones"},  out_ones,  n);
    check({tag, "_eq"},    out_eq,    e);
  endtask

  logic [W-1:0] oh [5];

  initial begin
    oh[0] = 4'b0001; oh[1] = 4'b0010; oh[2] = 4'b0100;
    oh[3] = 4'b1000; oh[4] = 4'b0001;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ref_data  = '0;
    out_ready = 1'b1;
    clr_stats = 1'b0;
    #1;
    check("rst_valid",  out_valid,  1'b0);
    check("rst_ready",  in_ready,   1'b1);
    check("rst_class",  out_class,  3'd0);
    check("rst_ones",   out_ones,   3'd0);
    check("rst_eq",     out_eq,     1'b0);
    check("rst_onehot", cnt_onehot, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    send(4'b1000, 4'b0000);
    expect_out("oh", CLS_ONEHOT, 3'd1, 1'b0);
    check("oh_cnt", cnt_onehot, 2'd1);
    send(4'b1111, 4'b0000);
    expect_out("all", CLS_ALLONES, 3'd4, 1'b0);
    send(4'b0110, 4'b0000);
    expect_out("multi", CLS_MULTI, 3'd2, 1'b0);
    send(4'b0000, 4'b0000);
    expect_out("zero", CLS_ZERO, 3'd0, 1'b1);
    send(4'b1110, 4'b1110);
    expect_out("eq1", CLS_MULTI, 3'd3, 1'b1);
    send(4'b1110, 4'b1111);
    expect_out("eq0", CLS_MULTI, 3'd3, 1'b0);
`ifdef VIM_XCHK_EN
    send(4'b111x, 4'b1110);
    expect_out("unk", CLS_UNKNOWN, 3'd0, 1'b0);
    check("unk_cnt", cnt_unknown, 2'd1);
`endif

    // Backpressure: result must hold for 3 cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'b0100;
    ref_data  = 4'b0000;
    @(posedge clk); #1;
    in_data = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1'b1);
      check("stall_class", out_class, CLS_ONEHOT);
      check("stall_ones",  out_ones,  3'd1);
      check("stall_ready", in_ready,  1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_out("rel", CLS_MULTI, 3'd2, 1'b0);

    // Saturation at CNT_W=2, then clear vs transfer
    @(posedge clk); #1;
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = oh[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("sat_onehot", cnt_onehot, 2'd3);
    @(posedge clk); #1;
    clr_stats = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'b1111;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("clr_class",   out_class,   CLS_ALLONES);
    check("clr_zero",    cnt_zero,    2'd0);
    check("clr_onehot",  cnt_onehot,  2'd0);
    check("clr_allones", cnt_allones, 2'd0);
    check("clr_multi",   cnt_multi,   2'd0);
    check("clr_unknown", cnt_unknown, 2'd0);

    // Reset drops a pending result
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'b0110, 4'b0110);
    check("pend_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_ready", in_ready,  1'b1);
    check("arst_ones",  out_ones,  3'd0);
    check("arst_multi", cnt_multi, 2'd0);
    @(posedge clk); #1;
    check("arst_ready2", in_ready, 1'b1);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_stats = ($urandom_range(0, 19) == 0);
      in_data   = W'($urandom);
      ref_data  = ($urandom_range(0, 1) != 0) ? in_data : W'($urandom);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    clr_stats = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    check("end_valid",  out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
